// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, single-outstanding instruction-memory requests and a
// small instruction queue feeding the scoreboard, with redirect, drain and halt handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        freeze,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_miss,
  input  logic [31:0] branch_target,
  input  logic        fetch_halt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        halted
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_mem    [FQ_DEPTH];
  logic [31:0]   instr_mem [FQ_DEPTH];

  logic        redirect;
  logic [31:0] redir_tgt;
  logic        resp;
  logic        push;
  logic        pop;
  logic        can_issue;

  always_comb begin
    redirect  = branch_miss | jump;
    redir_tgt = branch_miss ? branch_target : jump_target;
    resp      = req_q & imem_ready;
    // Responses arriving while draining belong to a squashed path and never enter the queue.
    push      = resp & (state_q != DRAIN) & ~redirect;
    pop       = fetch_valid & ~freeze & ~redirect;
    // With nothing outstanding the reservation check reduces to a free queue slot.
    can_issue = (state_q == RUN) & ~req_q & ~fetch_halt & ~redirect & (count_q < CW'(FQ_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem[tail_q]    <= addr_q;
        instr_mem[tail_q] <= imem_rdata;
        tail_q            <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);

      if (redirect) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        pc_q    <= redir_tgt;
        if (req_q & ~imem_ready) begin
          state_q <= DRAIN;
        end else begin
          state_q <= RUN;
          req_q   <= 1'b0;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (resp) begin
              req_q <= 1'b0;
              pc_q  <= pc_q + 32'd4;
            end else if (can_issue) begin
              req_q  <= 1'b1;
              addr_q <= pc_q;
            end
            if (fetch_halt) state_q <= HALT;
          end
          HALT: begin
            if (resp) begin
              req_q <= 1'b0;
              pc_q  <= pc_q + 32'd4;
            end
          end
          DRAIN: begin
            if (imem_ready) begin
              req_q   <= 1'b0;
              state_q <= RUN;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    fetch_valid = (count_q != '0);
    fetch_pc    = fetch_valid ? pc_mem[head_q]    : '0;
    fetch_instr = fetch_valid ? instr_mem[head_q] : '0;
    halted      = (state_q == HALT);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end stage directly upstream of the scoreboard.
- Generates the PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a small instruction queue and presents them to the scoreboard one per cycle.
- Honours scoreboard back-pressure (freeze), decode redirects (jump), execute redirects (branch_miss) and fetch_halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 4, instruction-queue entries (power of two, ≥2).

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- imem_req  output  1  request valid; held until imem_ready
- imem_addr  output  32  word-aligned fetch address; stable while imem_req
- imem_ready  input  1  response valid this cycle; completes the request
- imem_rdata  input  32  instruction word, valid with imem_ready
- freeze  input  1  scoreboard cannot accept this cycle
- jump  input  1  decode-resolved redirect
- jump_target  input  32  target for jump
- branch_miss  input  1  execute-resolved mispredict
- branch_target  input  32  correct PC for branch_miss
- fetch_halt  input  1  halt decoded; stop fetching
- fetch_valid  output  1  queue head valid
- fetch_instr  output  32  queue head instruction
- fetch_pc  output  32  PC of queue head
- halted  output  1  fetch FSM in HALT

Behaviour:
- Reset (RST high at a CLK edge) applies regardless of state or outstanding request:
  - pc=RESET_PC, queue empty, FSM=RUN.
  - imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=0, halted=0.
  - Any in-flight response after reset is ignored; the memory handshake is restarted.
- Queue:
  - FIFO of {pc, instr}; count width $clog2(FQ_DEPTH)+1; pointers wrap modulo FQ_DEPTH.
  - fetch_valid = (count != 0); head fields are driven combinationally from the head entry.
  - pop = fetch_valid & ~freeze.
  - Push occurs on an accepted response (imem_ready in RUN with no redirect).
  - Simultaneous push and pop with a full queue is legal; count is unchanged.
- Request issue (RUN):
  - imem_req=1 when (count + outstanding) < FQ_DEPTH. Outstanding is at most 1, so a request is never issued without a slot reserved.
  - imem_addr=pc. Once asserted, imem_req and imem_addr hold until imem_ready.
  - On imem_ready: push {pc, imem_rdata}, pc += 4 (32-bit wrap). imem_req may reassert in the next cycle. There is no back-to-back issue in the response cycle.
- FSM states: RUN, DRAIN, HALT.
  - Redirect priority: branch_miss > jump.
  - On redirect (any state):
    - Queue is flushed (count=0, fetch_valid=0 next cycle). Any same-cycle pop or push is discarded.
    - pc = branch_target or jump_target.
  - If a request is outstanding and imem_ready=0 at the redirect, go to DRAIN. DRAIN keeps imem_req/imem_addr stable at the stale address.
  - If imem_ready=1 in the redirect cycle, that response is dropped and the next state is RUN.
  - DRAIN → RUN on imem_ready. The response is discarded and pc is not incremented.
  - A second redirect while in DRAIN overwrites pc and stays in DRAIN.
  - fetch_halt in RUN (no redirect) → HALT:
    - No new requests.
    - An outstanding request completes and its word is pushed.
    - The queue keeps draining to the scoreboard.
  - In HALT, halted=1 and imem_req=0 after the outstanding request completes.
  - Redirect in HALT (a speculative halt being squashed) follows the redirect rules and leaves HALT.
  - fetch_halt and a redirect in the same cycle: the redirect wins; fetch_halt is ignored.
- Latency: first fetch_valid no earlier than the cycle after imem_ready for the first request.

Test Plan:
- Reset, imem_ready one cycle after every request, freeze=0 → fetch_pc sequence 0x0, 0x4, 0x8, …, one instruction per 2 cycles; halted=0.
- freeze=1 for 10 cycles, FQ_DEPTH=4 → exactly 4 entries pushed, imem_req=0 until a pop; head stable at 0x0/instr0; release yields 0x0, 0x4, 0x8, 0xC in order, no loss or duplication.
- Outstanding request to 0x10 with memory latency 3; branch_miss=1, branch_target=0x200 in cycle 1 → DRAIN; response for 0x10 discarded; next imem_addr=0x200; first fetch_pc=0x200; fetch_valid=0 through the drain.
- jump (target 0x80) and branch_miss (target 0x400) in the same cycle → pc=0x400, queue flushed.
- fetch_halt with 2 queued entries and 1 outstanding → 3 more instructions delivered, then imem_req stays 0 and halted=1; a subsequent branch_miss to 0x40 → halted=0, fetching resumes at 0x40.
- RST asserted while in DRAIN with a pending response → outputs at reset values next cycle; late imem_ready ignored; fetch restarts at RESET_PC.
